// File: rtl/sisc_rf_sb_pkg.sv
// Shared constants for the SISC register file: default widths and status flag bit positions.
package sisc_rf_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_STAT_W = 4;

  // Bit positions of the ALU flags inside stat_in / stat_out.
  typedef enum logic [1:0] {
    STAT_C = 2'd0,
    STAT_V = 2'd1,
    STAT_N = 2'd2,
    STAT_Z = 2'd3
  } stat_bit_e;

endpackage

// File: rtl/sisc_rd_port.sv
// One combinational read port: array lookup, optional write-through forwarding and busy lookup.
module sisc_rd_port
  import sisc_rf_sb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic [ADDR_W-1:0]               addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   regs,
  input  logic [2**ADDR_W-1:0]            busy,
  input  logic                            wr_eff,
  input  logic [ADDR_W-1:0]               wa,
  input  logic [DATA_W-1:0]               wd,
  output logic [DATA_W-1:0]               data,
  output logic                            hazard
);

  logic is_zero;
  logic fwd;

  always_comb begin
    is_zero = ZERO_R0 && (addr == '0);
    fwd     = BYPASS && wr_eff && (wa == addr);
    data    = regs[int'(addr)*DATA_W +: DATA_W];
    hazard  = busy[addr];
    // A same-cycle write both supplies the data and retires the pending claim.
    if (fwd) begin
      data   = wd;
      hazard = 1'b0;
    end
    if (is_zero) begin
      data   = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/sisc_rf_sb.sv
// SISC register file with status register and per-register busy scoreboard for RAW stalls.
module sisc_rf_sb
  import sisc_rf_sb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NRD     = 2,
  parameter int STAT_W  = DEF_STAT_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ok,
  input  logic [STAT_W-1:0]        stat_in,
  input  logic                     stat_en,
  output logic [STAT_W-1:0]        stat_out,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]       regs [NREGS];
  logic [NREGS*DATA_W-1:0] regs_flat;
  logic [NREGS-1:0]        busy;
  logic [NREGS-1:0]        busy_nxt;
  logic [STAT_W-1:0]       stat;
  logic                    wr_eff;
  logic                    claim_set;

  assign wr_eff = we && !(ZERO_R0 && (wa == '0));

  // A busy target is still claimable when its writeback lands in the same cycle.
  assign claim_ok  = claim_en && (!busy[claim_addr] || (we && (wa == claim_addr)));
  assign claim_set = claim_ok && !(ZERO_R0 && (claim_addr == '0));

  always_comb begin
    busy_nxt = busy;
    if (wr_eff)    busy_nxt[wa]         = 1'b0;
    if (claim_set) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      busy <= '0;
      stat <= '0;
    end else begin
      if (wr_eff)  regs[wa] <= wd;
      busy <= busy_nxt;
      if (stat_en) stat <= stat_in;
    end
  end

  assign busy_vec = busy;
  assign stat_out = stat;

  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = regs[k];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    sisc_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS)
    ) u_port (
      .addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs  (regs_flat),
      .busy  (busy),
      .wr_eff(wr_eff),
      .wa    (wa),
      .wd    (wd),
      .data  (rd_data[i*DATA_W +: DATA_W]),
      .hazard(rd_busy[i])
    );
  end

endmodule

// File: tb/tb_sisc_rf_sb.sv
// Directed bench for sisc_rf_sb: default instance plus a 16-bit, 3-port, no-bypass instance.
module tb_sisc_rf_sb;

  logic clk;
  logic rst_f;

  // Default instance (A)
  logic [7:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we;
  logic [3:0]  a_wa;
  logic [31:0] a_wd;
  logic        a_claim_en;
  logic [3:0]  a_claim_addr;
  logic        a_claim_ok;
  logic [3:0]  a_stat_in;
  logic        a_stat_en;
  logic [3:0]  a_stat_out;
  logic [15:0] a_busy_vec;

  // Swept instance (B): DATA_W=16, ADDR_W=3, NRD=3, BYPASS=0
  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_we;
  logic [2:0]  b_wa;
  logic [15:0] b_wd;
  logic        b_claim_en;
  logic [2:0]  b_claim_addr;
  logic        b_claim_ok;
  logic [3:0]  b_stat_in;
  logic        b_stat_en;
  logic [3:0]  b_stat_out;
  logic [7:0]  b_busy_vec;

  sisc_rf_sb dut_a (
    .clk(clk), .rst_f(rst_f),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we(a_we), .wa(a_wa), .wd(a_wd),
    .claim_en(a_claim_en), .claim_addr(a_claim_addr), .claim_ok(a_claim_ok),
    .stat_in(a_stat_in), .stat_en(a_stat_en), .stat_out(a_stat_out),
    .busy_vec(a_busy_vec)
  );

  sisc_rf_sb #(.DATA_W(16), .ADDR_W(3), .NRD(3), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_f(rst_f),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we(b_we), .wa(b_wa), .wd(b_wd),
    .claim_en(b_claim_en), .claim_addr(b_claim_addr), .claim_ok(b_claim_ok),
    .stat_in(b_stat_in), .stat_en(b_stat_en), .stat_out(b_stat_out),
    .busy_vec(b_busy_vec)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef enum int {
    A_RD0, A_RD1, A_RDB0, A_RDB1, A_CLAIM, A_STAT, A_BUSY,
    B_RD0, B_RD1, B_RD2, B_RDB0, B_RDB2, B_CLAIM, B_BUSY
  } sel_e;

  logic [31:0] exp_q[$];
  sel_e        sel_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      A_RD0:   return a_rd_data[31:0];
      A_RD1:   return a_rd_data[63:32];
      A_RDB0:  return {31'd0, a_rd_busy[0]};
      A_RDB1:  return {31'd0, a_rd_busy[1]};
      A_CLAIM: return {31'd0, a_claim_ok};
      A_STAT:  return {28'd0, a_stat_out};
      A_BUSY:  return {16'd0, a_busy_vec};
      B_RD0:   return {16'd0, b_rd_data[15:0]};
      B_RD1:   return {16'd0, b_rd_data[31:16]};
      B_RD2:   return {16'd0, b_rd_data[47:32]};
      B_RDB0:  return {31'd0, b_rd_busy[0]};
      B_RDB2:  return {31'd0, b_rd_busy[2]};
      B_CLAIM: return {31'd0, b_claim_ok};
      B_BUSY:  return {24'd0, b_busy_vec};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_val(input sel_e s, input logic [31:0] v);
    sel_q.push_back(s);
    exp_q.push_back(v);
  endtask

  // Monitor: expectations queued during a cycle are checked on the following falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic sel_e        s = sel_q.pop_front();
      automatic logic [31:0] e = exp_q.pop_front();
      automatic logic [31:0] g = observe(s);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s t=%0t got=%h exp=%h", s.name(), $time, g, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_rd_addr = '0; a_we = 0; a_wa = '0; a_wd = '0;
    a_claim_en = 0; a_claim_addr = '0; a_stat_in = '0; a_stat_en = 0;
    b_rd_addr = '0; b_we = 0; b_wa = '0; b_wd = '0;
    b_claim_en = 0; b_claim_addr = '0; b_stat_in = '0; b_stat_en = 0;
  endtask

  initial begin
    rst_f = 1'b0;
    idle_inputs();
    step();
    step();
    rst_f = 1'b1;
    a_rd_addr = {4'd0, 4'd3};
    expect_val(A_RD0, 32'h0);
    expect_val(A_STAT, 32'h0);
    expect_val(A_BUSY, 32'h0);
    expect_val(A_CLAIM, 32'h0);

    // 1. reset clears stored data and status, overriding a same-cycle write
    step();
    a_we = 1; a_wa = 4'd3; a_wd = 32'hDEAD_BEEF; a_stat_en = 1; a_stat_in = 4'b1010;
    step();
    a_we = 0; a_stat_en = 0;
    expect_val(A_RD0, 32'hDEAD_BEEF);
    expect_val(A_STAT, 32'hA);
    step();
    rst_f = 0; a_we = 1; a_wa = 4'd3; a_wd = 32'h1; a_claim_en = 1; a_claim_addr = 4'd3;
    a_stat_en = 1; a_stat_in = 4'b0101;
    step();
    rst_f = 1; a_we = 0; a_claim_en = 0; a_stat_en = 0;
    expect_val(A_RD0, 32'h0);
    expect_val(A_STAT, 32'h0);
    expect_val(A_BUSY, 32'h0);

    // 2. write-through bypass, then stored value
    step();
    a_we = 1; a_wa = 4'd5; a_wd = 32'h1234; a_rd_addr = {4'd3, 4'd5};
    expect_val(A_RD0, 32'h1234);
    expect_val(A_RD1, 32'h0);
    step();
    a_we = 0; a_rd_addr = {4'd5, 4'd5};
    expect_val(A_RD0, 32'h1234);
    expect_val(A_RD1, 32'h1234);

    // 3. R0 ignores writes and claims
    step();
    a_we = 1; a_wa = 4'd0; a_wd = 32'hFFFF_FFFF; a_claim_en = 1; a_claim_addr = 4'd0;
    a_rd_addr = {4'd0, 4'd0};
    expect_val(A_CLAIM, 32'h1);
    expect_val(A_RD0, 32'h0);
    expect_val(A_RDB0, 32'h0);
    step();
    a_we = 0; a_claim_en = 0;
    expect_val(A_RD1, 32'h0);
    expect_val(A_BUSY, 32'h0);
    expect_val(A_RDB1, 32'h0);

    // 4. RAW hazard on R7
    step();
    a_claim_en = 1; a_claim_addr = 4'd7;
    expect_val(A_CLAIM, 32'h1);
    step();
    a_rd_addr = {4'd7, 4'd0};
    expect_val(A_CLAIM, 32'h0);
    expect_val(A_RDB1, 32'h1);
    expect_val(A_BUSY, 32'h0080);
    step();
    a_claim_en = 0; a_we = 1; a_wa = 4'd7; a_wd = 32'h55;
    expect_val(A_RD1, 32'h55);
    expect_val(A_RDB1, 32'h0);
    expect_val(A_BUSY, 32'h0080);
    step();
    a_we = 0;
    expect_val(A_BUSY, 32'h0);
    expect_val(A_RD1, 32'h55);
    expect_val(A_RDB1, 32'h0);

    // 5. write + claim of a busy R9 in the same cycle: claim wins
    step();
    a_claim_en = 1; a_claim_addr = 4'd9;
    expect_val(A_CLAIM, 32'h1);
    step();
    a_we = 1; a_wa = 4'd9; a_wd = 32'hCAFE;
    expect_val(A_CLAIM, 32'h1);
    step();
    a_we = 0; a_claim_en = 0; a_rd_addr = {4'd5, 4'd9};
    expect_val(A_RD0, 32'hCAFE);
    expect_val(A_RDB0, 32'h1);
    expect_val(A_BUSY, 32'h0200);
    expect_val(A_RD1, 32'h1234);

    // 6. swept instance: no bypass, three independent ports
    step();
    b_claim_en = 1; b_claim_addr = 3'd4; b_we = 1; b_wa = 3'd1; b_wd = 16'h1111;
    expect_val(B_CLAIM, 32'h1);
    step();
    b_claim_en = 0; b_wa = 3'd2; b_wd = 16'h2222; b_rd_addr = {3'd0, 3'd0, 3'd2};
    expect_val(B_RD0, 32'h0);
    step();
    b_wa = 3'd3; b_wd = 16'h3333; b_rd_addr = {3'd3, 3'd2, 3'd1};
    expect_val(B_RD0, 32'h1111);
    expect_val(B_RD1, 32'h2222);
    expect_val(B_RD2, 32'h0);
    step();
    b_wa = 3'd4; b_wd = 16'h4444; b_rd_addr = {3'd4, 3'd0, 3'd4};
    expect_val(B_RD0, 32'h0);
    expect_val(B_RDB0, 32'h1);
    expect_val(B_RDB2, 32'h1);
    expect_val(B_BUSY, 32'h10);
    step();
    b_we = 0; b_rd_addr = {3'd3, 3'd2, 3'd1};
    expect_val(B_RD0, 32'h1111);
    expect_val(B_RD1, 32'h2222);
    expect_val(B_RD2, 32'h3333);
    expect_val(B_BUSY, 32'h0);
    step();
    b_rd_addr = {3'd4, 3'd0, 3'd4};
    expect_val(B_RD0, 32'h4444);
    expect_val(B_RD1, 32'h0);
    expect_val(B_RD2, 32'h4444);
    expect_val(B_RDB0, 32'h0);

    // drain scoreboard with a bounded wait
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count got=%0d exp>=12", checks);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
